// File: rtl/capture_controller.sv
// Capture sequencer for the scope sample shift register: gates pushes, detects the
// trigger edge, counts post-trigger samples and freezes the frame until it is displayed.
module capture_controller #(
  parameter int DATA_W       = 10,
  parameter int DEPTH        = 640,
  parameter int TRIG_POS     = 600,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_sample,
  input  logic [DATA_W-1:0] i_level,
  input  logic              i_falling,
  input  logic [1:0]        i_mode,
  input  logic              i_arm,
  input  logic              i_stop,
  input  logic              i_frame_done,
  output logic              o_push,
  output logic [2:0]        o_state,
  output logic              o_frame_ready,
  output logic              o_trig_pulse,
  output logic              o_auto_fired
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMO_W = $clog2(AUTO_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PREFILL = 3'd1;
  localparam logic [2:0] S_ARMED   = 3'd2;
  localparam logic [2:0] S_POST    = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TRIG_POS_C = CNT_W'(TRIG_POS);
  localparam logic [CNT_W-1:0] POST_LEN_C = CNT_W'(DEPTH - 1 - TRIG_POS);
  localparam logic [TMO_W-1:0] TMO_ZERO   = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] TMO_ONE    = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LIMIT  = TMO_W'(AUTO_TIMEOUT);

  logic [2:0]        state_r,    state_s;
  logic [CNT_W-1:0]  pre_cnt_r,  pre_cnt_s;
  logic [CNT_W-1:0]  post_cnt_r, post_cnt_s;
  logic [TMO_W-1:0]  tmo_cnt_r,  tmo_cnt_s;
  logic [DATA_W-1:0] prev_r;
  logic              prev_valid_r;
  logic              trig_pulse_r, trig_s;
  logic              auto_fired_r, auto_s;
  logic              frame_ready_r;
  logic              capturing_s, push_s;
  logic              rise_s, fall_s, hit_s;

  // Push gating and edge detection against the previous valid sample
  always_comb begin
    capturing_s = (state_r == S_PREFILL) || (state_r == S_ARMED) || (state_r == S_POST);
    push_s      = i_sample_valid & capturing_s & ~i_stop;
    rise_s      = prev_valid_r & (prev_r <  i_level) & (i_sample >= i_level);
    fall_s      = prev_valid_r & (prev_r >= i_level) & (i_sample <  i_level);
    if (i_falling) begin
      hit_s = fall_s;
    end else begin
      hit_s = rise_s;
    end
  end

  // Next-state and counter logic; i_stop overrides everything
  always_comb begin
    state_s    = state_r;
    pre_cnt_s  = pre_cnt_r;
    post_cnt_s = post_cnt_r;
    tmo_cnt_s  = tmo_cnt_r;
    trig_s     = 1'b0;
    auto_s     = 1'b0;
    if (i_stop) begin
      state_s    = S_IDLE;
      pre_cnt_s  = CNT_ZERO;
      post_cnt_s = CNT_ZERO;
      tmo_cnt_s  = TMO_ZERO;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (i_arm) begin
            state_s   = S_PREFILL;
            pre_cnt_s = CNT_ZERO;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_PREFILL: begin
          // With the trigger at column 0 there is nothing to prefill
          if (TRIG_POS_C == CNT_ZERO) begin
            state_s   = S_ARMED;
            tmo_cnt_s = TMO_ZERO;
          end else if (push_s) begin
            pre_cnt_s = pre_cnt_r + CNT_ONE;
            if (pre_cnt_s == TRIG_POS_C) begin
              state_s   = S_ARMED;
              tmo_cnt_s = TMO_ZERO;
            end else begin
              state_s = S_PREFILL;
            end
          end else begin
            state_s = S_PREFILL;
          end
        end
        S_ARMED: begin
          if (push_s) begin
            if (hit_s) begin
              trig_s = 1'b1;
            end else if (i_mode == MODE_AUTO) begin
              tmo_cnt_s = tmo_cnt_r + TMO_ONE;
              if (tmo_cnt_s == TMO_LIMIT) begin
                trig_s = 1'b1;
                auto_s = 1'b1;
              end else begin
                trig_s = 1'b0;
              end
            end else begin
              trig_s = 1'b0;
            end
            if (trig_s) begin
              post_cnt_s = POST_LEN_C;
              if (POST_LEN_C == CNT_ZERO) begin
                state_s = S_HOLD;
              end else begin
                state_s = S_POST;
              end
            end else begin
              state_s = S_ARMED;
            end
          end else begin
            state_s = S_ARMED;
          end
        end
        S_POST: begin
          if (push_s) begin
            post_cnt_s = post_cnt_r - CNT_ONE;
            if (post_cnt_s == CNT_ZERO) begin
              state_s = S_HOLD;
            end else begin
              state_s = S_POST;
            end
          end else begin
            state_s = S_POST;
          end
        end
        S_HOLD: begin
          if (i_frame_done) begin
            if (i_mode == MODE_SINGLE) begin
              state_s = S_IDLE;
            end else begin
              state_s   = S_PREFILL;
              pre_cnt_s = CNT_ZERO;
            end
          end else begin
            state_s = S_HOLD;
          end
        end
        default: begin
          state_s    = S_IDLE;
          pre_cnt_s  = CNT_ZERO;
          post_cnt_s = CNT_ZERO;
          tmo_cnt_s  = TMO_ZERO;
        end
      endcase
    end
  end

  // State, counters and registered pulse outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r       <= S_IDLE;
      pre_cnt_r     <= CNT_ZERO;
      post_cnt_r    <= CNT_ZERO;
      tmo_cnt_r     <= TMO_ZERO;
      trig_pulse_r  <= 1'b0;
      auto_fired_r  <= 1'b0;
      frame_ready_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      pre_cnt_r     <= pre_cnt_s;
      post_cnt_r    <= post_cnt_s;
      tmo_cnt_r     <= tmo_cnt_s;
      trig_pulse_r  <= trig_s;
      auto_fired_r  <= auto_s;
      frame_ready_r <= (state_s == S_HOLD);
    end
  end

  // Previous-sample history runs in every state, independent of capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_r       <= {DATA_W{1'b0}};
      prev_valid_r <= 1'b0;
    end else if (i_sample_valid) begin
      prev_r       <= i_sample;
      prev_valid_r <= 1'b1;
    end else begin
      prev_r       <= prev_r;
      prev_valid_r <= prev_valid_r;
    end
  end

  assign o_push        = push_s;
  assign o_state       = state_r;
  assign o_frame_ready = frame_ready_r;
  assign o_trig_pulse  = trig_pulse_r;
  assign o_auto_fired  = auto_fired_r;

endmodule

// File: tb/tb_capture_controller.sv
// Directed bench for capture_controller (DEPTH=8, TRIG_POS=5, AUTO_TIMEOUT=4) with an
// expectation queue filled at drive time and drained when outputs are sampled.
module tb_capture_controller;

  logic       clk;
  logic       rst_n;
  logic       sample_valid;
  logic [9:0] sample;
  logic [9:0] level;
  logic       falling;
  logic [1:0] mode;
  logic       arm;
  logic       stop;
  logic       frame_done;
  logic       push;
  logic [2:0] state;
  logic       frame_ready;
  logic       trig_pulse;
  logic       auto_fired;

  typedef struct {
    logic       push;
    logic [2:0] state;
    logic       trig;
    logic       aut;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  capture_controller #(
    .DATA_W(10), .DEPTH(8), .TRIG_POS(5), .AUTO_TIMEOUT(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_valid(sample_valid), .i_sample(sample),
    .i_level(level), .i_falling(falling), .i_mode(mode), .i_arm(arm), .i_stop(stop),
    .i_frame_done(frame_done), .o_push(push), .o_state(state), .o_frame_ready(frame_ready),
    .o_trig_pulse(trig_pulse), .o_auto_fired(auto_fired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clock: drive inputs, queue expectations, sample o_push at negedge, rest after the edge
  task automatic cyc(input logic v, input logic [9:0] s, input logic a, input logic st,
                     input logic fd, input logic e_push, input logic [2:0] e_state,
                     input logic e_trig, input logic e_auto);
    exp_t e;
    logic obs_push;
    sample_valid = v; sample = s; arm = a; stop = st; frame_done = fd;
    e.push = e_push; e.state = e_state; e.trig = e_trig; e.aut = e_auto;
    sb.push_back(e);
    @(negedge clk);
    obs_push = push;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("push", {31'd0, obs_push}, {31'd0, e.push});
    check("state", {29'd0, state}, {29'd0, e.state});
    check("frame_ready", {31'd0, frame_ready}, {31'd0, (e.state == 3'd4)});
    check("trig_pulse", {31'd0, trig_pulse}, {31'd0, e.trig});
    check("auto_fired", {31'd0, auto_fired}, {31'd0, e.aut});
  endtask

  task automatic prefill(input logic [9:0] s);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, s, 1'b0, 1'b0, 1'b0, 1'b1, (i == 4) ? 3'd2 : 3'd1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; sample_valid = 1'b0; sample = 10'd0; level = 10'd35; falling = 1'b0;
    mode = 2'd0; arm = 1'b0; stop = 1'b0; frame_done = 1'b0;
    #2;
    check("rst_push", {31'd0, push}, 32'd0);
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_ready", {31'd0, frame_ready}, 32'd0);
    check("rst_trig", {31'd0, trig_pulse}, 32'd0);
    check("rst_auto", {31'd0, auto_fired}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Rising ramp, level 35, normal mode: trigger on 40 after 30
    cyc(1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    cyc(1'b1, 10'd0,  1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    cyc(1'b1, 10'd0,  1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    cyc(1'b1, 10'd10, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    cyc(1'b1, 10'd20, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    cyc(1'b1, 10'd30, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    cyc(1'b1, 10'd40, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
    cyc(1'b1, 10'd50, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    cyc(1'b1, 10'd60, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    cyc(1'b1, 10'd70, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
    cyc(1'b1, 10'd80, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
    cyc(1'b1, 10'd90, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);

    // Re-armed from HOLD: arm/frame_done ignored in ARMED, stop in POST
    prefill(10'd0);
    cyc(1'b1, 10'd0,  1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    cyc(1'b1, 10'd0,  1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    cyc(1'b1, 10'd40, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
    cyc(1'b1, 10'd50, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc(1'b1, 10'd60, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 10'd0,  1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 10'd0,  1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    // Auto mode with a flat signal: fourth ARMED sample forces the trigger
    mode = 2'd1;
    cyc(1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    prefill(10'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, (i == 3) ? 3'd3 : 3'd2, (i == 3), (i == 3));
    end
    cyc(1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    cyc(1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    mode = 2'd2;
    cyc(1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    // Normal mode with the same flat signal never times out
    mode = 2'd0;
    cyc(1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    prefill(10'd0);
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    end
    cyc(1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Falling edge at level 50: 60->50 misses, 50->49 hits
    falling = 1'b1; level = 10'd50;
    cyc(1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    prefill(10'd60);
    cyc(1'b1, 10'd60, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    cyc(1'b1, 10'd50, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    cyc(1'b1, 10'd49, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
    cyc(1'b0, 10'd0,  1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Rising onto the level itself (49 -> 50), then async reset while in POST
    falling = 1'b0; mode = 2'd2;
    cyc(1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    prefill(10'd49);
    cyc(1'b1, 10'd49, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    cyc(1'b1, 10'd50, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
    sample_valid = 1'b1; sample = 10'd60; arm = 1'b0; stop = 1'b0; frame_done = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_push", {31'd0, push}, 32'd0);
    check("arst_state", {29'd0, state}, 32'd0);
    check("arst_ready", {31'd0, frame_ready}, 32'd0);
    check("arst_trig", {31'd0, trig_pulse}, 32'd0);
    check("arst_auto", {31'd0, auto_fired}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; sample_valid = 1'b0;

    // Clean restart after reset with a full prefill, then single-mode release to IDLE
    cyc(1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    prefill(10'd49);
    cyc(1'b1, 10'd50, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
    cyc(1'b1, 10'd60, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    cyc(1'b1, 10'd70, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    cyc(1'b1, 10'd80, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
    cyc(1'b1, 10'd90, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 10'd0,  1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
